// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared types and helpers for the ping-pong operand register file.
//   fill_state_t : fill-side FSM states (FILL accepts rows, FULL waits to swap)
//   bank_sel_t   : selects one of the two storage banks
//   rf_idx_w()   : row index / row counter width for a given tile depth
// -----------------------------------------------------------------------------
package rf_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_t;

    typedef logic bank_sel_t;

    localparam bank_sel_t BANK0 = 1'b0;
    localparam bank_sel_t BANK1 = 1'b1;

    // Row index width; a one-row tile still needs a 1-bit index port.
    function automatic int rf_idx_w(input int depth);
        int w;
        if (depth < 2) begin
            w = 1;
        end else begin
            w = $clog2(depth);
        end
        return w;
    endfunction

endpackage

// File: rtl/rf_bank.sv
// -----------------------------------------------------------------------------
// rf_bank
// One DEPTH x LANES x WIDTH operand storage array (X or W half of one bank).
// Storage is deliberately not reset.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   widx   in   row to write
//   wdata  in   row data, lane i at [i*WIDTH +: WIDTH]
//   ridx   in   row to read (combinational)
//   rdata  out  row data; zero when ridx is beyond the last row
// -----------------------------------------------------------------------------
module rf_bank
    import rf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [rf_idx_w(DEPTH)-1:0]   widx,
    input  logic [LANES*WIDTH-1:0]       wdata,
    input  logic [rf_idx_w(DEPTH)-1:0]   ridx,
    output logic [LANES*WIDTH-1:0]       rdata
);

    localparam int IW = rf_idx_w(DEPTH);
    localparam int RW = LANES * WIDTH;
    localparam logic [IW:0] DEPTH_EXT = (IW+1)'(DEPTH);

    logic [RW-1:0] r_mem [DEPTH];
    logic          w_ridx_ok;

    assign w_ridx_ok = ({1'b0, ridx} < DEPTH_EXT);

    // Row write port; the fill FSM only ever presents in-range rows.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[widx] <= wdata;
        end
    end

    // Combinational row read, guarded so non-power-of-two depths never index past the array.
    always_comb begin
        rdata = '0;
        if (w_ridx_ok) begin
            rdata = r_mem[ridx];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/operand_rf_pp.sv
// -----------------------------------------------------------------------------
// operand_rf_pp
// Ping-pong operand register file feeding the multiplier array. Two banks each
// hold one X tile and one W tile of DEPTH rows x LANES lanes x WIDTH bits.
// The loader fills the fill bank over a valid/ready port while the multiplier
// reads the other bank; banks swap once the fill bank is full and the read
// bank is free (no valid tile, or released this cycle).
//
// Optional feature macro: RF_ZERO_FLAG_EN
//   defined   : x_zero/w_zero per-lane zero flags registered with read data
//   undefined : those ports and their logic are absent
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   ld_valid/ready   load row handshake; ld_x/ld_w carry the row
//   tile_valid       read bank holds a complete tile
//   tile_release     one-cycle pulse, multiplier done with the read bank
//   rd_en, rd_idx    read request and row index
//   rd_x, rd_w       read data (one-cycle latency), rd_out_valid qualifies it
//   x_zero, w_zero   per-lane zero flags (RF_ZERO_FLAG_EN only)
// -----------------------------------------------------------------------------
module operand_rf_pp
    import rf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [LANES*WIDTH-1:0]       ld_x,
    input  logic [LANES*WIDTH-1:0]       ld_w,
    output logic                         tile_valid,
    input  logic                         tile_release,
    input  logic                         rd_en,
    input  logic [rf_idx_w(DEPTH)-1:0]   rd_idx,
    output logic [LANES*WIDTH-1:0]       rd_x,
    output logic [LANES*WIDTH-1:0]       rd_w,
    output logic                         rd_out_valid
`ifdef RF_ZERO_FLAG_EN
    ,
    output logic [LANES-1:0]             x_zero,
    output logic [LANES-1:0]             w_zero
`endif
);

    localparam int IW = rf_idx_w(DEPTH);
    localparam int RW = LANES * WIDTH;
    localparam logic [IW-1:0] ROW_LAST  = IW'(DEPTH - 1);
    localparam logic [IW:0]   DEPTH_EXT = (IW+1)'(DEPTH);

    // Fill-side state
    fill_state_t   r_state;
    fill_state_t   w_state_nxt;
    logic [IW-1:0] r_row_cnt;
    logic [IW-1:0] w_row_nxt;
    bank_sel_t     r_fill_bank;
    logic          r_ld_ready;
    logic          r_tile_valid;
    logic          w_tile_valid_nxt;
    logic          w_swap;
    logic          w_hs;

    // Read-side signals
    bank_sel_t     w_rd_bank;
    logic          w_rd_ok;
    logic [RW-1:0] w_x0_rdata;
    logic [RW-1:0] w_w0_rdata;
    logic [RW-1:0] w_x1_rdata;
    logic [RW-1:0] w_w1_rdata;
    logic [RW-1:0] w_rd_x_sel;
    logic [RW-1:0] w_rd_w_sel;
    logic [RW-1:0] r_rd_x;
    logic [RW-1:0] r_rd_w;
    logic          r_rd_out_valid;
    logic          w_we0;
    logic          w_we1;

    assign w_hs      = ld_valid & r_ld_ready;
    assign w_we0     = w_hs & (r_fill_bank == BANK0);
    assign w_we1     = w_hs & (r_fill_bank == BANK1);
    assign w_rd_bank = ~r_fill_bank;
    assign w_rd_ok   = rd_en & r_tile_valid & ({1'b0, rd_idx} < DEPTH_EXT);

    // -------------------------------------------------------------------------
    // Storage: X and W arrays for each bank. Writes only ever target the fill
    // bank, so a same-row fill and read in one cycle touch different arrays.
    // -------------------------------------------------------------------------
    rf_bank #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) u_x0 (
        .clk(clk), .we(w_we0), .widx(r_row_cnt), .wdata(ld_x), .ridx(rd_idx), .rdata(w_x0_rdata)
    );
    rf_bank #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) u_w0 (
        .clk(clk), .we(w_we0), .widx(r_row_cnt), .wdata(ld_w), .ridx(rd_idx), .rdata(w_w0_rdata)
    );
    rf_bank #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) u_x1 (
        .clk(clk), .we(w_we1), .widx(r_row_cnt), .wdata(ld_x), .ridx(rd_idx), .rdata(w_x1_rdata)
    );
    rf_bank #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) u_w1 (
        .clk(clk), .we(w_we1), .widx(r_row_cnt), .wdata(ld_w), .ridx(rd_idx), .rdata(w_w1_rdata)
    );

    // Select the read bank's row; uses the current (pre-swap) bank selection.
    always_comb begin
        w_rd_x_sel = w_x0_rdata;
        w_rd_w_sel = w_w0_rdata;
        if (w_rd_bank == BANK1) begin
            w_rd_x_sel = w_x1_rdata;
            w_rd_w_sel = w_w1_rdata;
        end else begin
            w_rd_x_sel = w_x0_rdata;
            w_rd_w_sel = w_w0_rdata;
        end
    end

    // Fill FSM next-state, row counter, swap decision and tile_valid update.
    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row_cnt;
        w_swap           = 1'b0;
        w_tile_valid_nxt = r_tile_valid;
        case (r_state)
            FILL: begin
                if (w_hs) begin
                    if (r_row_cnt == ROW_LAST) begin
                        w_row_nxt   = '0;
                        w_state_nxt = FULL;
                    end else begin
                        w_row_nxt   = r_row_cnt + IW'(1);
                        w_state_nxt = FILL;
                    end
                end else begin
                    w_row_nxt   = r_row_cnt;
                    w_state_nxt = FILL;
                end
            end
            FULL: begin
                // Swap as soon as the read bank is free, including on the release cycle itself.
                if (!r_tile_valid || tile_release) begin
                    w_swap      = 1'b1;
                    w_state_nxt = FILL;
                end else begin
                    w_swap      = 1'b0;
                    w_state_nxt = FULL;
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_row_nxt   = '0;
            end
        endcase

        // A swap wins over a same-cycle release, so the new tile is valid immediately.
        if (w_swap) begin
            w_tile_valid_nxt = 1'b1;
        end else if (tile_release) begin
            w_tile_valid_nxt = 1'b0;
        end else begin
            w_tile_valid_nxt = r_tile_valid;
        end
    end

    // Fill-side state registers; reset discards any partial fill and valid tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FILL;
            r_row_cnt    <= '0;
            r_fill_bank  <= BANK0;
            r_ld_ready   <= 1'b1;
            r_tile_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_row_cnt    <= w_row_nxt;
            r_fill_bank  <= w_swap ? ~r_fill_bank : r_fill_bank;
            r_ld_ready   <= (w_state_nxt == FILL);
            r_tile_valid <= w_tile_valid_nxt;
        end
    end

    // Read output registers: invalid requests return zeros, idle cycles hold data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_x         <= '0;
            r_rd_w         <= '0;
            r_rd_out_valid <= 1'b0;
        end else if (rd_en) begin
            if (w_rd_ok) begin
                r_rd_x         <= w_rd_x_sel;
                r_rd_w         <= w_rd_w_sel;
                r_rd_out_valid <= 1'b1;
            end else begin
                r_rd_x         <= '0;
                r_rd_w         <= '0;
                r_rd_out_valid <= 1'b0;
            end
        end else begin
            r_rd_out_valid <= 1'b0;
        end
    end

    assign ld_ready     = r_ld_ready;
    assign tile_valid   = r_tile_valid;
    assign rd_x         = r_rd_x;
    assign rd_w         = r_rd_w;
    assign rd_out_valid = r_rd_out_valid;

`ifdef RF_ZERO_FLAG_EN
    logic [LANES-1:0] r_x_zero;
    logic [LANES-1:0] r_w_zero;

    // One flag per lane: set when that lane of the row is all zeros.
    function automatic logic [LANES-1:0] lane_zero(input logic [RW-1:0] row);
        logic [LANES-1:0] z;
        z = '0;
        for (int i = 0; i < LANES; i++) begin
            z[i] = (row[i*WIDTH +: WIDTH] == '0);
        end
        return z;
    endfunction

    // Zero flags track rd_out_valid: only meaningful alongside valid read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_zero <= '0;
            r_w_zero <= '0;
        end else if (w_rd_ok) begin
            r_x_zero <= lane_zero(w_rd_x_sel);
            r_w_zero <= lane_zero(w_rd_w_sel);
        end else begin
            r_x_zero <= '0;
            r_w_zero <= '0;
        end
    end

    assign x_zero = r_x_zero;
    assign w_zero = r_w_zero;
`endif

endmodule

// File: tb/tb_operand_rf_pp.sv
// -----------------------------------------------------------------------------
// tb_operand_rf_pp
// Scoreboard bench for operand_rf_pp. Reads push their expected response into
// a queue; a monitor pops and compares one cycle after each read request.
// A second, DEPTH=3 instance covers the out-of-range row index case.
// -----------------------------------------------------------------------------
module tb_operand_rf_pp;

    typedef struct {
        logic        v;
        logic [63:0] x;
        logic [63:0] w;
        logic [7:0]  xz;
        logic [7:0]  wz;
    } exp_t;

    exp_t sb_q[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_ready, tile_valid, tile_release, rd_en, rd_out_valid;
    logic [63:0] ld_x, ld_w, rd_x, rd_w;
    logic [1:0]  rd_idx;

    logic        ld_valid3, ld_ready3, tile_valid3, tile_release3, rd_en3, rd_out_valid3;
    logic [63:0] ld_x3, ld_w3, rd_x3, rd_w3;
    logic [1:0]  rd_idx3;

`ifdef RF_ZERO_FLAG_EN
    logic [7:0]  x_zero, w_zero, x_zero3, w_zero3;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    operand_rf_pp #(.WIDTH(8), .LANES(8), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_x(ld_x), .ld_w(ld_w),
        .tile_valid(tile_valid), .tile_release(tile_release),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_x(rd_x), .rd_w(rd_w),
        .rd_out_valid(rd_out_valid)
`ifdef RF_ZERO_FLAG_EN
        , .x_zero(x_zero), .w_zero(w_zero)
`endif
    );

    operand_rf_pp #(.WIDTH(8), .LANES(8), .DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid3), .ld_ready(ld_ready3), .ld_x(ld_x3), .ld_w(ld_w3),
        .tile_valid(tile_valid3), .tile_release(tile_release3),
        .rd_en(rd_en3), .rd_idx(rd_idx3), .rd_x(rd_x3), .rd_w(rd_w3),
        .rd_out_valid(rd_out_valid3)
`ifdef RF_ZERO_FLAG_EN
        , .x_zero(x_zero3), .w_zero(w_zero3)
`endif
    );

    // Row pattern: lane l of row r = base + r*16 + l
    function automatic logic [63:0] mk(input logic [7:0] base, input int row);
        logic [63:0] r;
        for (int l = 0; l < 8; l++) begin
            r[l*8 +: 8] = base + 8'(row * 16) + 8'(l);
        end
        return r;
    endfunction

    function automatic logic [7:0] zf(input logic [63:0] row);
        logic [7:0] z;
        for (int l = 0; l < 8; l++) begin
            z[l] = (row[l*8 +: 8] == 8'h00);
        end
        return z;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic v, input logic [63:0] x, input logic [63:0] w,
                        input logic [7:0] xz, input logic [7:0] wz);
        exp_t e;
        e.v = v; e.x = x; e.w = w; e.xz = xz; e.wz = wz;
        sb_q.push_back(e);
    endtask

    task automatic push_row(input logic [63:0] x);
        push(1'b1, x, ~x, zf(x), zf(~x));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one cycle after a main-DUT read request, pop and compare.
    initial begin
        logic issued;
        exp_t e;
        forever begin
            @(posedge clk);
            issued = rd_en;
            @(negedge clk);
            if (issued) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL sb_underflow: got read response expected none queued");
                end else begin
                    e = sb_q.pop_front();
                    chk("rd_out_valid", {63'd0, rd_out_valid}, {63'd0, e.v});
                    chk("rd_x", rd_x, e.x);
                    chk("rd_w", rd_w, e.w);
`ifdef RF_ZERO_FLAG_EN
                    chk("x_zero", {56'd0, x_zero}, {56'd0, e.xz});
                    chk("w_zero", {56'd0, w_zero}, {56'd0, e.wz});
`endif
                end
            end
        end
    end

    initial begin
        logic [63:0] zrow;
        rst = 1'b1;
        ld_valid = 1'b0; ld_x = 64'd0; ld_w = 64'd0; tile_release = 1'b0;
        rd_en = 1'b0; rd_idx = 2'd0;
        ld_valid3 = 1'b0; ld_x3 = 64'd0; ld_w3 = 64'd0; tile_release3 = 1'b0;
        rd_en3 = 1'b0; rd_idx3 = 2'd0;
        step(); step();

        // Reset values
        chk("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
        chk("rst_tile_valid", {63'd0, tile_valid}, 64'd0);
        chk("rst_rd_out_valid", {63'd0, rd_out_valid}, 64'd0);
        chk("rst_rd_x", rd_x, 64'd0);
        chk("rst_rd_w", rd_w, 64'd0);
        rst = 1'b0;
        step();

        // Test 1: first tile, ld_valid held for 4 rows
        for (int r = 0; r < 4; r++) begin
            ld_valid = 1'b1; ld_x = mk(8'h00, r); ld_w = ~mk(8'h00, r);
            step();
            chk("t1_ld_ready", {63'd0, ld_ready}, (r == 3) ? 64'd0 : 64'd1);
            chk("t1_tile_valid", {63'd0, tile_valid}, 64'd0);
        end
        ld_valid = 1'b0;
        step();
        chk("t1_tile_valid_set", {63'd0, tile_valid}, 64'd1);
        chk("t1_ld_ready_back", {63'd0, ld_ready}, 64'd1);

        // Test 2: reads of tile 1
        rd_en = 1'b1; rd_idx = 2'd2; push_row(mk(8'h00, 2));
        step();
        chk("t2_lane3", {56'd0, rd_x[31:24]}, 64'h23);
        rd_idx = 2'd0; push_row(mk(8'h00, 0));
        step();
        rd_idx = 2'd3; push_row(mk(8'h00, 3));
        step();
        rd_en = 1'b0;
        step();
        chk("t2_idle_valid", {63'd0, rd_out_valid}, 64'd0);
        chk("t2_idle_hold", rd_x, 64'h3736353433323130);

        // Test 3: fill tile 2 while reading the same rows of tile 1
        for (int r = 0; r < 4; r++) begin
            ld_valid = 1'b1; ld_x = mk(8'h40, r); ld_w = ~mk(8'h40, r);
            rd_en = 1'b1; rd_idx = 2'(r); push_row(mk(8'h00, r));
            step();
        end
        ld_valid = 1'b0; rd_en = 1'b0;
        chk("t3_ld_ready_full", {63'd0, ld_ready}, 64'd0);
        step(); step();
        chk("t3_hold_ld_ready", {63'd0, ld_ready}, 64'd0);
        chk("t3_hold_tile_valid", {63'd0, tile_valid}, 64'd1);
        tile_release = 1'b1; rd_en = 1'b1; rd_idx = 2'd1; push_row(mk(8'h00, 1));
        step();
        tile_release = 1'b0;
        chk("t3_swap_tile_valid", {63'd0, tile_valid}, 64'd1);
        chk("t3_swap_ld_ready", {63'd0, ld_ready}, 64'd1);
        rd_idx = 2'd1; push_row(mk(8'h40, 1));
        step();
        rd_idx = 2'd3; push_row(mk(8'h40, 3));
        step();
        rd_en = 1'b0;

        // Test 4: release with no pending tile, then reads/releases with tile_valid=0
        tile_release = 1'b1;
        step();
        tile_release = 1'b0;
        chk("t4_tile_valid_clr", {63'd0, tile_valid}, 64'd0);
        rd_en = 1'b1; rd_idx = 2'd0; push(1'b0, 64'd0, 64'd0, 8'h00, 8'h00);
        step();
        rd_en = 1'b0; tile_release = 1'b1;
        step();
        tile_release = 1'b0;
        chk("t4_ign_tile_valid", {63'd0, tile_valid}, 64'd0);
        chk("t4_ign_ld_ready", {63'd0, ld_ready}, 64'd1);

        // Test 5: reset after 2 rows, then a full tile must land in bank 0
        for (int r = 0; r < 2; r++) begin
            ld_valid = 1'b1; ld_x = mk(8'h60, r); ld_w = ~mk(8'h60, r);
            step();
        end
        ld_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("t5_ld_ready", {63'd0, ld_ready}, 64'd1);
        chk("t5_tile_valid", {63'd0, tile_valid}, 64'd0);
        chk("t5_rd_out_valid", {63'd0, rd_out_valid}, 64'd0);
        chk("t5_rd_x", rd_x, 64'd0);
        step();
        rst = 1'b0;
        step();
        zrow = mk(8'h50, 3);
        zrow[7:0]   = 8'h00;
        zrow[47:40] = 8'h00;
        for (int r = 0; r < 4; r++) begin
            ld_valid = 1'b1;
            ld_x = (r == 3) ? zrow : mk(8'h50, r);
            ld_w = (r == 3) ? ~zrow : ~mk(8'h50, r);
            step();
        end
        ld_valid = 1'b0;
        step();
        chk("t5_tile_valid_set", {63'd0, tile_valid}, 64'd1);
        // Test 6 row: lanes 0 and 5 zero
        rd_en = 1'b1; rd_idx = 2'd3; push(1'b1, zrow, ~zrow, 8'b0010_0001, 8'b0000_0000);
        step();
        rd_idx = 2'd0; push_row(mk(8'h50, 0));
        step();
        rd_idx = 2'd1; push_row(mk(8'h50, 1));
        step();
        rd_en = 1'b0;

        // DEPTH=3 instance: last row and out-of-range index
        for (int r = 0; r < 3; r++) begin
            ld_valid3 = 1'b1; ld_x3 = mk(8'h30, r); ld_w3 = ~mk(8'h30, r);
            step();
        end
        ld_valid3 = 1'b0;
        chk("d3_ld_ready_full", {63'd0, ld_ready3}, 64'd0);
        step();
        chk("d3_tile_valid", {63'd0, tile_valid3}, 64'd1);
        rd_en3 = 1'b1; rd_idx3 = 2'd2;
        step();
        chk("d3_last_valid", {63'd0, rd_out_valid3}, 64'd1);
        chk("d3_last_x", rd_x3, mk(8'h30, 2));
        rd_idx3 = 2'd3;
        step();
        rd_en3 = 1'b0;
        chk("d3_oor_valid", {63'd0, rd_out_valid3}, 64'd0);
        chk("d3_oor_x", rd_x3, 64'd0);
        chk("d3_oor_w", rd_w3, 64'd0);
`ifdef RF_ZERO_FLAG_EN
        chk("d3_oor_x_zero", {56'd0, x_zero3}, 64'd0);
        chk("d3_oor_w_zero", {56'd0, w_zero3}, 64'd0);
`endif

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            step();
        end
        if (sb_q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
